// File: rtl/crossbar_pkg.sv
// Shared types and width helpers for the queued crossbar master.
package crossbar_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_IDLE = 3'b010,
    ST_REQ  = 3'b100
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Packed command layout, MSB first: {oper, addr, wdata}
  function automatic int cmd_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head word is read combinationally.
module sync_fifo #(
  parameter int pWidth = 8,
  parameter int pDepth = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iPush,
  input  logic                      iPop,
  input  logic [pWidth-1:0]         iData,
  output logic [pWidth-1:0]         oData,
  output logic                      oFull,
  output logic                      oEmpty,
  output logic [$clog2(pDepth):0]   oCount
);

  localparam int PTR_W = $clog2(pDepth);

  logic [pWidth-1:0] mem_q [pDepth];
  logic [pWidth-1:0] mem_d [pDepth];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok, pop_ok;

  assign oFull   = (count_q == (PTR_W+1)'(pDepth));
  assign oEmpty  = (count_q == '0);
  assign oCount  = count_q;
  assign oData   = mem_q[rd_ptr_q];
  // Full is judged on the registered count, so a pop never makes room for a same-cycle push
  assign push_ok = iPush && !oFull;
  assign pop_ok  = iPop && !oEmpty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = iData;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge iClk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/crossbar_master_q.sv
// Crossbar master that queues local read/write commands and issues them one at a time
// on the req/ack interface, with optional ack timeout.
module crossbar_master_q
  import crossbar_pkg::*;
#(
  parameter int pAddr_W     = 32,
  parameter int pData_W     = 32,
  parameter int pFifo_Depth = 4,
  parameter int pInit_Delay = 10,
  parameter int pTimeout    = 0
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic               iOper,
  input  logic [pAddr_W-1:0] iAddr,
  input  logic [pData_W-1:0] iWrite_Data,
  output logic               oFull,
  output logic               oOverflow,
  output logic               oBusy,
  output logic [pData_W-1:0] oRdata,
  output logic               oRvalid,
  output logic               oWr_done,
  output logic               oTimeout,
  output logic               master_req,
  output logic [pAddr_W-1:0] master_addr,
  output logic               master_cmd,
  output logic [pData_W-1:0] master_wdata,
  input  logic               master_ack,
  input  logic [pData_W-1:0] master_rdata
);

  localparam int CMD_W  = cmd_width(pAddr_W, pData_W);
  localparam int CNT_W  = $clog2(pFifo_Depth) + 1;
  localparam int INIT_W = $clog2(pInit_Delay + 1);
  localparam int WAIT_W = (pTimeout > 1) ? $clog2(pTimeout) : 1;
  localparam logic [INIT_W-1:0] INIT_LIM = INIT_W'(pInit_Delay);
  // The wait counter holds the number of completed REQ cycles; the last allowed one is pTimeout-1
  localparam logic [WAIT_W-1:0] WAIT_LIM = (pTimeout > 0) ? WAIT_W'(pTimeout - 1) : '0;

  state_e             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               req_q, req_d;
  logic [pAddr_W-1:0] addr_q, addr_d;
  logic               cmd_q, cmd_d;
  logic [pData_W-1:0] wdata_q, wdata_d;
  logic [pData_W-1:0] rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               wr_done_q, wr_done_d;
  logic               timeout_q, timeout_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;

  logic [CMD_W-1:0]   fifo_din, fifo_dout;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count, count_nxt;
  logic               push_ok;

  assign fifo_din = {iOper, iAddr, iWrite_Data};
  assign push_ok  = iStart && !fifo_full;

  sync_fifo #(
    .pWidth (CMD_W),
    .pDepth (pFifo_Depth)
  ) u_cmd_fifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPush  (iStart),
    .iPop   (fifo_pop),
    .iData  (fifo_din),
    .oData  (fifo_dout),
    .oFull  (fifo_full),
    .oEmpty (fifo_empty),
    .oCount (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    wr_done_d  = 1'b0;
    timeout_d  = 1'b0;
    overflow_d = iStart && fifo_full;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LIM) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cmd_d      = fifo_dout[CMD_W-1];
          addr_d     = fifo_dout[pAddr_W+pData_W-1 -: pAddr_W];
          wdata_d    = fifo_dout[pData_W-1:0];
          req_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the limit cycle takes priority over the timeout
        if (master_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (cmd_q == CMD_READ) begin
            rdata_d  = master_rdata;
            rvalid_d = 1'b1;
          end else begin
            wr_done_d = 1'b1;
          end
        end else if ((pTimeout > 0) && (wait_cnt_q == WAIT_LIM)) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (pTimeout > 0) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = INIT_W'(1);
        req_d      = 1'b0;
      end
    endcase

    count_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(fifo_pop);
    busy_d    = (state_d != ST_IDLE) || (count_nxt != '0);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_W'(1);
      wait_cnt_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      wr_done_q  <= wr_done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  assign oFull        = fifo_full;
  assign oOverflow    = overflow_q;
  assign oBusy        = busy_q;
  assign oRdata       = rdata_q;
  assign oRvalid      = rvalid_q;
  assign oWr_done     = wr_done_q;
  assign oTimeout     = timeout_q;
  assign master_req   = req_q;
  assign master_addr  = addr_q;
  assign master_cmd   = cmd_q;
  assign master_wdata = wdata_q;

endmodule

// File: tb/tb_crossbar_master_q.sv
// Scenario bench for crossbar_master_q: pushed commands go to a scoreboard queue and are
// compared when issued on the crossbar; acked read data is queued and compared on oRvalid.
module tb_crossbar_master_q;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int INIT  = 10;
  localparam int TO    = 8;

  logic          iClk = 1'b0;
  logic          iRst, iStart, iOper;
  logic [AW-1:0] iAddr;
  logic [DW-1:0] iWrite_Data;
  logic          oFull, oOverflow, oBusy, oRvalid, oWr_done, oTimeout;
  logic [DW-1:0] oRdata;
  logic          master_req, master_cmd, master_ack;
  logic [AW-1:0] master_addr;
  logic [DW-1:0] master_wdata, master_rdata;

  int checks   = 0;
  int failures = 0;
  logic [AW+DW:0] exp_q[$];
  logic [DW-1:0]  rd_q[$];
  logic [DW-1:0]  last_rd;

  crossbar_master_q #(
    .pAddr_W(AW), .pData_W(DW), .pFifo_Depth(DEPTH), .pInit_Delay(INIT), .pTimeout(TO)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iOper(iOper), .iAddr(iAddr),
    .iWrite_Data(iWrite_Data), .oFull(oFull), .oOverflow(oOverflow), .oBusy(oBusy),
    .oRdata(oRdata), .oRvalid(oRvalid), .oWr_done(oWr_done), .oTimeout(oTimeout),
    .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
    .master_wdata(master_wdata), .master_ack(master_ack), .master_rdata(master_rdata)
  );

  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge iClk);
  endtask

  task automatic push_cmd(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit accept);
    iStart = 1'b1; iOper = op; iAddr = a; iWrite_Data = d;
    step();
    iStart = 1'b0;
    if (accept) exp_q.push_back({op, a, d});
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (master_req !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic ack_cycle(input logic [DW-1:0] rd);
    master_ack = 1'b1; master_rdata = rd;
    step();
    master_ack = 1'b0; master_rdata = '0;
  endtask

  task automatic do_reset();
    iRst = 1'b1; iStart = 1'b0; iOper = 1'b0; iAddr = '0; iWrite_Data = '0;
    master_ack = 1'b0; master_rdata = '0;
    step();
    step();
    iRst = 1'b0;
    exp_q.delete();
    rd_q.delete();
  endtask

  function automatic logic [AW+DW:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic logic [DW-1:0] pop_rd();
    if (rd_q.size() == 0) return 'x;
    return rd_q.pop_front();
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({master_req, oRvalid, oWr_done, oTimeout, oFull, oOverflow, oBusy} !== 7'b0000001) begin
      failures++;
      $display("FAIL reset_flags actual=%b required=0000001",
               {master_req, oRvalid, oWr_done, oTimeout, oFull, oOverflow, oBusy});
    end
    checks++;
    if (oRdata !== '0 || master_addr !== '0 || master_wdata !== '0) begin
      failures++;
      $display("FAIL reset_data actual=%h/%h/%h required=0", oRdata, master_addr, master_wdata);
    end
  endtask

  task automatic test_init_read();
    logic [AW+DW:0] exp;
    logic [DW-1:0]  rd;
    int cyc;
    step();
    push_cmd(1'b0, 32'h10, 32'h0, 1'b1);
    wait_req(cyc);
    checks++;
    if (cyc + 2 != INIT + 1) begin
      failures++;
      $display("FAIL init_req_edge actual=%0d required=%0d", cyc + 2, INIT + 1);
    end
    exp = pop_exp();
    checks++;
    if ({master_cmd, master_addr, master_wdata} !== exp) begin
      failures++;
      $display("FAIL init_fields actual=%h required=%h", {master_cmd, master_addr, master_wdata}, exp);
    end
    rd_q.push_back(32'hDEADBEEF);
    ack_cycle(32'hDEADBEEF);
    rd = pop_rd();
    checks++;
    if (master_req !== 1'b0 || oRvalid !== 1'b1 || oRdata !== rd) begin
      failures++;
      $display("FAIL init_ack actual=req%b vld%b %h required=req0 vld1 %h", master_req, oRvalid, oRdata, rd);
    end
    step();
    checks++;
    if (oRvalid !== 1'b0 || oRdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL init_pulse actual=vld%b %h required=vld0 deadbeef", oRvalid, oRdata);
    end
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_back_to_back();
    logic [AW+DW:0] exp;
    logic [DW-1:0]  rd;
    int cyc, stable;
    push_cmd(1'b1, 32'h20, 32'hA5A5A5A5, 1'b1);
    push_cmd(1'b0, 32'h24, 32'h0, 1'b1);
    wait_req(cyc);
    exp = pop_exp();
    checks++;
    if ({master_cmd, master_addr, master_wdata} !== exp) begin
      failures++;
      $display("FAIL b2b_wr_fields actual=%h required=%h", {master_cmd, master_addr, master_wdata}, exp);
    end
    stable = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (master_req === 1'b1 && {master_cmd, master_addr, master_wdata} === exp) stable++;
    end
    checks++;
    if (stable != 3) begin
      failures++;
      $display("FAIL b2b_stable actual=%0d required=3", stable);
    end
    ack_cycle(32'hFFFF0000);
    checks++;
    if (oWr_done !== 1'b1 || oRvalid !== 1'b0 || master_req !== 1'b0 || oRdata !== last_rd) begin
      failures++;
      $display("FAIL b2b_wr_done actual=wd%b vld%b req%b %h required=wd1 vld0 req0 %h",
               oWr_done, oRvalid, master_req, oRdata, last_rd);
    end
    wait_req(cyc);
    checks++;
    if (cyc != 1) begin
      failures++;
      $display("FAIL b2b_gap actual=%0d required=1", cyc);
    end
    exp = pop_exp();
    checks++;
    if ({master_cmd, master_addr, master_wdata} !== exp) begin
      failures++;
      $display("FAIL b2b_rd_fields actual=%h required=%h", {master_cmd, master_addr, master_wdata}, exp);
    end
    rd_q.push_back(32'h12345678);
    ack_cycle(32'h12345678);
    rd = pop_rd();
    checks++;
    if (oRvalid !== 1'b1 || oWr_done !== 1'b0 || oRdata !== rd) begin
      failures++;
      $display("FAIL b2b_rd_done actual=vld%b wd%b %h required=vld1 wd0 %h", oRvalid, oWr_done, oRdata, rd);
    end
    last_rd = 32'h12345678;
  endtask

  task automatic test_overflow();
    logic [AW+DW:0] exp;
    logic [DW-1:0]  rd;
    int cyc, done, extra;
    do_reset();
    step();
    push_cmd(1'b0, 32'h100, 32'h0, 1'b1);
    push_cmd(1'b1, 32'h104, 32'h11110000, 1'b1);
    push_cmd(1'b0, 32'h108, 32'h0, 1'b1);
    checks++;
    if (oFull !== 1'b0) begin
      failures++;
      $display("FAIL ovf_not_full actual=%b required=0", oFull);
    end
    push_cmd(1'b1, 32'h10C, 32'h22220000, 1'b1);
    checks++;
    if (oFull !== 1'b1 || master_req !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full actual=full%b req%b required=full1 req0", oFull, master_req);
    end
    push_cmd(1'b1, 32'h1FC, 32'h00000BAD, 1'b0);
    checks++;
    if (oOverflow !== 1'b1 || oFull !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pulse actual=ovf%b full%b required=ovf1 full1", oOverflow, oFull);
    end
    step();
    checks++;
    if (oOverflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pulse_end actual=%b required=0", oOverflow);
    end
    done = 0;
    for (int i = 0; i < 4; i++) begin
      wait_req(cyc);
      exp = pop_exp();
      checks++;
      if (master_req !== 1'b1 || {master_cmd, master_addr, master_wdata} !== exp) begin
        failures++;
        $display("FAIL ovf_fields%0d actual=req%b %h required=req1 %h", i, master_req,
                 {master_cmd, master_addr, master_wdata}, exp);
      end
      if (exp[AW+DW] == 1'b0) rd_q.push_back(32'hCAFE0000 + DW'(i));
      ack_cycle(32'hCAFE0000 + DW'(i));
      if (exp[AW+DW] == 1'b0) begin
        rd = pop_rd();
        if (oRvalid === 1'b1 && oRdata === rd) done++;
        last_rd = rd;
      end else if (oWr_done === 1'b1) begin
        done++;
      end
    end
    checks++;
    if (done != 4) begin
      failures++;
      $display("FAIL ovf_completions actual=%0d required=4", done);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (master_req === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || oBusy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ovf_dropped actual=extra%0d busy%b required=extra0 busy0", extra, oBusy);
    end
  endtask

  task automatic test_timeout();
    logic [AW+DW:0] exp;
    logic [DW-1:0]  rd;
    int cyc, hi;
    push_cmd(1'b0, 32'h300, 32'h0, 1'b1);
    push_cmd(1'b0, 32'h304, 32'h0, 1'b1);
    wait_req(cyc);
    exp = pop_exp();
    checks++;
    if ({master_cmd, master_addr, master_wdata} !== exp) begin
      failures++;
      $display("FAIL to_fields actual=%h required=%h", {master_cmd, master_addr, master_wdata}, exp);
    end
    hi = 0;
    while (master_req === 1'b1 && hi < 20) begin
      hi++;
      step();
    end
    checks++;
    if (hi != TO) begin
      failures++;
      $display("FAIL to_req_cycles actual=%0d required=%0d", hi, TO);
    end
    checks++;
    if (oTimeout !== 1'b1 || oRvalid !== 1'b0 || oRdata !== last_rd) begin
      failures++;
      $display("FAIL to_pulse actual=to%b vld%b %h required=to1 vld0 %h", oTimeout, oRvalid, oRdata, last_rd);
    end
    wait_req(cyc);
    exp = pop_exp();
    checks++;
    if (cyc != 1 || oTimeout !== 1'b0 || {master_cmd, master_addr, master_wdata} !== exp) begin
      failures++;
      $display("FAIL to_next actual=gap%0d to%b %h required=gap1 to0 %h", cyc, oTimeout,
               {master_cmd, master_addr, master_wdata}, exp);
    end
    rd_q.push_back(32'h0BADF00D);
    ack_cycle(32'h0BADF00D);
    rd = pop_rd();
    checks++;
    if (oRvalid !== 1'b1 || oRdata !== rd) begin
      failures++;
      $display("FAIL to_next_done actual=vld%b %h required=vld1 %h", oRvalid, oRdata, rd);
    end
    last_rd = 32'h0BADF00D;
  endtask

  task automatic test_ack_at_limit();
    logic [AW+DW:0] exp;
    logic [DW-1:0]  rd;
    int cyc, hi;
    push_cmd(1'b0, 32'h400, 32'h0, 1'b1);
    wait_req(cyc);
    exp = pop_exp();
    hi = 0;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      if (master_req === 1'b1) hi++;
    end
    checks++;
    if (hi != TO - 1 || {master_cmd, master_addr, master_wdata} !== exp) begin
      failures++;
      $display("FAIL lim_hold actual=%0d %h required=%0d %h", hi,
               {master_cmd, master_addr, master_wdata}, TO - 1, exp);
    end
    rd_q.push_back(32'h5A5A1234);
    ack_cycle(32'h5A5A1234);
    rd = pop_rd();
    checks++;
    if (oRvalid !== 1'b1 || oTimeout !== 1'b0 || oRdata !== rd) begin
      failures++;
      $display("FAIL lim_done actual=vld%b to%b %h required=vld1 to0 %h", oRvalid, oTimeout, oRdata, rd);
    end
    step();
    checks++;
    if (oTimeout !== 1'b0 || master_req !== 1'b0) begin
      failures++;
      $display("FAIL lim_no_to actual=to%b req%b required=to0 req0", oTimeout, master_req);
    end
    last_rd = 32'h5A5A1234;
  endtask

  task automatic test_reset_mid();
    logic [AW+DW:0] exp;
    int extra;
    push_cmd(1'b0, 32'h500, 32'h0, 1'b1);
    push_cmd(1'b1, 32'h504, 32'h77770000, 1'b1);
    push_cmd(1'b0, 32'h508, 32'h0, 1'b1);
    exp = pop_exp();
    checks++;
    if (master_req !== 1'b1 || {master_cmd, master_addr, master_wdata} !== exp) begin
      failures++;
      $display("FAIL mid_issue actual=req%b %h required=req1 %h", master_req,
               {master_cmd, master_addr, master_wdata}, exp);
    end
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    exp_q.delete();
    checks++;
    if (master_req !== 1'b0 || oBusy !== 1'b1 || oFull !== 1'b0 || oRdata !== '0) begin
      failures++;
      $display("FAIL mid_reset actual=req%b busy%b full%b %h required=req0 busy1 full0 0",
               master_req, oBusy, oFull, oRdata);
    end
    ack_cycle(32'hFEEDFACE);
    checks++;
    if (oRvalid !== 1'b0 || oWr_done !== 1'b0 || oRdata !== '0) begin
      failures++;
      $display("FAIL mid_stray_ack actual=vld%b wd%b %h required=vld0 wd0 0", oRvalid, oWr_done, oRdata);
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (master_req === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL mid_queue_flushed actual=extra%0d busy%b required=extra0 busy0", extra, oBusy);
    end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
